// File: rtl/piso_tx_pkg.sv
// Shared types and constants for the parallel-in serial-out transmitter.
// The optional parity stage is enabled with the PISO_TX_PARITY_EN macro.
package piso_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    localparam logic SOUT_IDLE = 1'b1;

    // The counter must hold WIDTH-1 at load time.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter with synchronous clear and a terminal-count flag.
// Used by piso_shift_tx to track the remaining data bits in a frame.
module piso_bit_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          clear,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          dec,
    output logic          tc
);

    localparam logic [CW-1:0] ONE = CW'(1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - ONE;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter with a complementary serial output pair.
// Defining PISO_TX_PARITY_EN appends an even-parity bit after the data bits.
module piso_shift_tx
    import piso_tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_bar,
    output logic             busy,
    output logic             done
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Handshake: a word transfers at a rising edge where din_valid and
    // din_ready are both high; din_valid may stay high while din_ready is low
    // and the word waits, unchanged, until the next IDLE edge accepts it.

    state_t           state, state_d;
    logic [WIDTH-1:0] sreg, sreg_rot;
    logic             first_bit, next_bit;
    logic             load, shift, tc;
    logic             sout_d, busy_d, done_d;

`ifdef PISO_TX_PARITY_EN
    logic par_q;

    always_ff @(posedge clk) begin
        if (clear) begin
            par_q <= 1'b0;
        end else if (load) begin
            par_q <= ^din;
        end
    end
`endif

    assign din_ready = (state == IDLE) && !clear;

    // The register rotates rather than shifts so no stored bit goes unread;
    // the bit leaving the output end is never presented again.
    always_comb begin
        if (MSB_FIRST) begin
            first_bit = din[WIDTH-1];
            next_bit  = sreg[WIDTH-2];
            sreg_rot  = {sreg[WIDTH-2:0], sreg[WIDTH-1]};
        end else begin
            first_bit = din[0];
            next_bit  = sreg[1];
            sreg_rot  = {sreg[0], sreg[WIDTH-1:1]};
        end
    end

    piso_bit_counter #(
        .CW(CW)
    ) u_bit_counter (
        .clk     (clk),
        .clear   (clear),
        .load    (load),
        .load_val(LAST),
        .dec     (shift),
        .tc      (tc)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        sout_d  = SOUT_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        case (state)
            IDLE: begin
                if (din_valid && din_ready) begin
                    load    = 1'b1;
                    state_d = SHIFT;
                    sout_d  = first_bit;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                if (!tc) begin
                    shift  = 1'b1;
                    sout_d = next_bit;
                    busy_d = 1'b1;
                end else begin
`ifdef PISO_TX_PARITY_EN
                    state_d = PAR;
                    sout_d  = par_q;
                    busy_d  = 1'b1;
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef PISO_TX_PARITY_EN
            PAR: begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // sout_bar is registered from the same next value so the pair never skews.
    always_ff @(posedge clk) begin
        if (clear) begin
            sreg     <= '0;
            sout     <= SOUT_IDLE;
            sout_bar <= ~SOUT_IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (load) begin
                sreg <= din;
            end else if (shift) begin
                sreg <= sreg_rot;
            end
            sout     <= sout_d;
            sout_bar <= ~sout_d;
            busy     <= busy_d;
            done     <= done_d;
        end
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: an MSB-first and an LSB-first instance share clk/clear.
// Expected serial tokens are queued at accept time and popped by a negedge monitor.
module tb_piso_shift_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         clear;
    logic [W-1:0] din_m, din_l;
    logic         val_m, val_l;
    logic         rdy_m, rdy_l;
    logic         sout_m, sout_l, sbar_m, sbar_l;
    logic         busy_m, busy_l, done_m, done_l;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    // Token 0/1: data or parity bit expected with busy=1; token 2: done cycle.
    logic [1:0] exp_m[$];
    logic [1:0] exp_l[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .clear(clear), .din(din_m), .din_valid(val_m), .din_ready(rdy_m),
        .sout(sout_m), .sout_bar(sbar_m), .busy(busy_m), .done(done_m)
    );

    piso_shift_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .clear(clear), .din(din_l), .din_valid(val_l), .din_ready(rdy_l),
        .sout(sout_l), .sout_bar(sbar_l), .busy(busy_l), .done(done_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon_step(input bit which, input logic so, input logic sb, input logic bz,
                            input logic dn, input logic rd);
        logic [1:0] tok;
        logic       nso;
        int         qsize;
        string      p;
        p     = which ? "lsb" : "msb";
        nso   = ~so;
        qsize = which ? exp_l.size() : exp_m.size();
        check({p, "_sout_bar"}, 32'(sb), 32'(nso));
        if (bz || dn) begin
            if (qsize == 0) begin
                total++;
                bad++;
                $display("FAIL %s_unexpected: got busy=%b done=%b expected idle", p, bz, dn);
            end else begin
                if (which) tok = exp_l.pop_front();
                else       tok = exp_m.pop_front();
                if (tok != 2'd2) begin
                    check({p, "_bit"},       32'(so), 32'(tok[0]));
                    check({p, "_bit_busy"},  32'(bz), 32'd1);
                    check({p, "_bit_done"},  32'(dn), 32'd0);
                    check({p, "_bit_ready"}, 32'(rd), 32'd0);
                end else begin
                    check({p, "_done"},      32'(dn), 32'd1);
                    check({p, "_done_busy"}, 32'(bz), 32'd0);
                    check({p, "_done_sout"}, 32'(so), 32'd1);
                end
            end
        end else begin
            check({p, "_idle_sout"}, 32'(so), 32'd1);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon_step(1'b0, sout_m, sbar_m, busy_m, done_m, rdy_m);
            mon_step(1'b1, sout_l, sbar_l, busy_l, done_l, rdy_l);
        end
    end

    // seq lists the expected line bits in transmit order, leftmost first.
    task automatic push_frame(input bit which, input logic [W-1:0] seq, input logic par);
        for (int i = W - 1; i >= 0; i--) begin
            if (which) exp_l.push_back({1'b0, seq[i]});
            else       exp_m.push_back({1'b0, seq[i]});
        end
`ifdef PISO_TX_PARITY_EN
        if (which) exp_l.push_back({1'b0, par});
        else       exp_m.push_back({1'b0, par});
`else
        if (par === 1'bz) $display("parity unused");
`endif
        if (which) exp_l.push_back(2'd2);
        else       exp_m.push_back(2'd2);
    endtask

    task automatic send(input bit which, input logic [W-1:0] w, input logic [W-1:0] seq,
                        input logic par, input bit hold, output int acc_cyc);
        bit ok = 1'b0;
        acc_cyc = -1;
        if (which) begin din_l = w; val_l = 1'b1; end
        else       begin din_m = w; val_m = 1'b1; end
        for (int c = 0; c < 40; c++) begin
            if (which ? rdy_l : rdy_m) begin
                @(posedge clk); #1;
                ok = 1'b1;
                acc_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        check(which ? "lsb_accept" : "msb_accept", 32'(ok), 32'd1);
        if (ok) push_frame(which, seq, par);
        if (!hold) begin
            if (which) begin val_l = 1'b0; din_l = ~w; end
            else       begin val_m = 1'b0; din_m = ~w; end
        end
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 60; c++) begin
            if (exp_m.size() == 0 && exp_l.size() == 0) break;
            @(posedge clk); #1;
        end
        check("drain_msb", 32'(exp_m.size()), 32'd0);
        check("drain_lsb", 32'(exp_l.size()), 32'd0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        int c1, c2, ca;
        int gap;
`ifdef PISO_TX_PARITY_EN
        gap = W + 2;
`else
        gap = W + 1;
`endif
        clear = 1'b1;
        val_m = 1'b1; din_m = 8'hA5;
        val_l = 1'b1; din_l = 8'h01;

        // Reset held with a word offered: nothing may be accepted.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rst_sout",     32'(sout_m), 32'd1);
            check("rst_sout_bar", 32'(sbar_m), 32'd0);
            check("rst_busy",     32'(busy_m), 32'd0);
            check("rst_done",     32'(done_m), 32'd0);
            check("rst_ready",    32'(rdy_m),  32'd0);
            check("rst_lsb_busy", 32'(busy_l), 32'd0);
            check("rst_lsb_rdy",  32'(rdy_l),  32'd0);
        end
        clear = 1'b0;
        val_m = 1'b0;
        val_l = 1'b0;
        mon_en = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy", 32'(busy_m), 32'd0);
        check("post_rst_rdy",  32'(rdy_m),  32'd1);

        // Single frames in each bit order.
        send(1'b0, 8'hA5, 8'b1010_0101, 1'b0, 1'b0, ca);
        wait_idle();
        send(1'b1, 8'h01, 8'b1000_0000, 1'b1, 1'b0, ca);
        wait_idle();

        // Back-to-back with din_valid held: exactly one idle cycle between frames.
        send(1'b0, 8'hFF, 8'b1111_1111, 1'b0, 1'b1, c1);
        send(1'b0, 8'h00, 8'b0000_0000, 1'b0, 1'b0, c2);
        check("b2b_gap", 32'(c2 - c1), 32'(gap));
        wait_idle();

        // Abort during the fourth bit of 8'hC3.
        send(1'b0, 8'hC3, 8'b1100_0011, 1'b0, 1'b0, ca);
        repeat (3) begin @(posedge clk); #1; end
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        exp_m.delete();
        check("abort_busy", 32'(busy_m), 32'd0);
        check("abort_done", 32'(done_m), 32'd0);
        check("abort_sout", 32'(sout_m), 32'd1);
        repeat (W + 3) begin @(posedge clk); #1; end
        send(1'b0, 8'h3C, 8'b0011_1100, 1'b0, 1'b0, ca);
        wait_idle();

        // Parity-carrying words (plain frames when parity is disabled).
        send(1'b0, 8'h07, 8'b0000_0111, 1'b1, 1'b0, ca);
        wait_idle();
        send(1'b0, 8'h03, 8'b0000_0011, 1'b0, 1'b0, ca);
        wait_idle();
        send(1'b1, 8'h07, 8'b1110_0000, 1'b1, 1'b0, ca);
        wait_idle();

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected test end");
        $fatal(1, "watchdog expired");
    end

endmodule
